// File: rtl/key_conditioner.sv
// key_conditioner
//   Synchronises and debounces raw active-low pushbuttons and produces clean
//   pressed levels, single-cycle press strobes, an any-key strobe and the
//   index of the lowest-numbered key that strobed.
//
// Ports
//   clock_50  : system clock (single clock domain)
//   reset     : synchronous, active-high reset
//   key_n     : raw asynchronous pushbuttons, active-low (0 = pressed)
//   key_level : debounced pressed state, 1 = pressed
//   key_pulse : one-cycle strobe per accepted press (and per auto-repeat)
//   any_pulse : OR of key_pulse
//   key_idx   : lowest channel with key_pulse high, holds otherwise
//
// Optional feature
//   KEYCOND_AUTOREPEAT_EN : when defined, a held key emits repeat strobes
//   REPEAT_DELAY cycles after the press strobe, then every REPEAT_PERIOD
//   cycles while it stays pressed. When undefined no repeat logic exists.

module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int IDX_W           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_pulse,
  output logic              any_pulse,
  output logic [IDX_W-1:0]  key_idx
);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, REL_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the logic cannot honour (index too narrow,
  // counter unable to reach its compare value, repeat timing inverted).
  if (((1 << IDX_W) < N_KEYS) || (DEBOUNCE_CYCLES < 1) ||
      ((DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) ||
      (REPEAT_PERIOD < 1) || (REPEAT_DELAY < REPEAT_PERIOD)) begin : g_bad_cfg
    $error("key_conditioner: invalid parameter set");
  end

  // Two-flop synchroniser; resets to the released (high) level.
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] p_sync;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  assign p_sync = ~sync2_q;

  // Per-channel next values for the registered outputs.
  logic [N_KEYS-1:0] level_d;
  logic [N_KEYS-1:0] pulse_d;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_evt;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      case (state_q)
        RELEASED: begin
          if (p_sync[gi]) begin
            state_d = PRESS_CHK;
            cnt_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!p_sync[gi]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = PRESSED;
            press_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!p_sync[gi]) begin
            state_d = REL_CHK;
            cnt_d   = '0;
          end
        end
        REL_CHK: begin
          if (p_sync[gi]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    // Level follows the next state so it rises in the same cycle as the strobe.
    assign level_d[gi] = (state_d == PRESSED) || (state_d == REL_CHK);

`ifdef KEYCOND_AUTOREPEAT_EN
    localparam int             REP_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes the next hit land PERIOD cycles later.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             stay_pressed;
    logic             rep_hit;

    assign stay_pressed = (state_q == PRESSED) && p_sync[gi];
    assign rep_hit      = stay_pressed && (rep_cnt_q == REP_LAST);

    always_comb begin
      rep_cnt_d = rep_cnt_q;
      if (!stay_pressed) begin
        // Cleared outside PRESSED and on every entry into PRESSED.
        rep_cnt_d = '0;
      end else if (rep_hit) begin
        rep_cnt_d = REP_RELOAD;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock_50) begin
      if (reset) begin
        rep_cnt_q <= '0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
      end
    end

    assign pulse_d[gi] = press_evt | rep_hit;
`else
    assign pulse_d[gi] = press_evt;
`endif

    always_ff @(posedge clock_50) begin
      if (reset) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  // Output stage.
  logic [N_KEYS-1:0] key_level_q, key_pulse_q;
  logic              any_pulse_q, any_pulse_d;
  logic [IDX_W-1:0]  key_idx_q, key_idx_d;

  always_comb begin
    any_pulse_d = |pulse_d;
    key_idx_d   = key_idx_q;
    // Descending scan so the lowest set channel wins.
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pulse_d[i]) begin
        key_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      key_level_q <= '0;
      key_pulse_q <= '0;
      any_pulse_q <= 1'b0;
      key_idx_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_level_q <= level_d;
      key_pulse_q <= pulse_d;
      any_pulse_q <= any_pulse_d;
      key_idx_q   <= key_idx_d;
    end
  end

  assign key_level = key_level_q;
  assign key_pulse = key_pulse_q;
  assign any_pulse = any_pulse_q;
  assign key_idx   = key_idx_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner: directed scenarios followed by random key
// activity, every cycle compared against a window-based reference model.

module tb_key_conditioner;

  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int W  = D + 3;

`ifdef KEYCOND_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clock_50 = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_pulse;
  logic       any_pulse;
  logic [1:0] key_idx;

  key_conditioner #(
    .N_KEYS(4), .IDX_W(2), .DEBOUNCE_CYCLES(D), .CNT_W(4),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .key_n    (key_n),
    .key_level(key_level),
    .key_pulse(key_pulse),
    .any_pulse(any_pulse),
    .key_idx  (key_idx)
  );

  always #5 clock_50 = ~clock_50;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: a channel's accepted level flips when the last D+1
  // synchronised samples (raw samples from 2..D+2 edges ago) all disagree.
  bit         samp    [4][W];
  bit         m_level [4];
  bit         m_inp   [4];   // held and most recent sample pressed
  int         m_entry [4];
  logic [3:0] m_pulse;
  logic [1:0] m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0] lv;
    @(posedge clock_50);
    cyc++;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < W; j++) samp[c][j] = 1'b0;
        m_level[c] = 1'b0;
        m_inp[c]   = 1'b0;
      end
      m_pulse = '0;
      m_idx   = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        bit all_diff, new_lvl, new_inp, rep;
        int k;
        for (int j = W - 1; j > 0; j--) samp[c][j] = samp[c][j-1];
        samp[c][0] = ~key_n[c];
        all_diff = 1'b1;
        for (int j = 2; j < W; j++) if (samp[c][j] == m_level[c]) all_diff = 1'b0;
        new_lvl = all_diff ? ~m_level[c] : m_level[c];
        new_inp = new_lvl && samp[c][2];
        rep = 1'b0;
        if (AR && m_inp[c] && new_inp) begin
          k   = cyc - m_entry[c];
          rep = (k >= RD) && ((k - RD) % RP == 0);
        end
        if (new_inp && !m_inp[c]) m_entry[c] = cyc;
        m_pulse[c] = (!m_level[c] && new_lvl) || rep;
        m_level[c] = new_lvl;
        m_inp[c]   = new_inp;
      end
      for (int c = 3; c >= 0; c--) if (m_pulse[c]) m_idx = 2'(c);
    end
    #1;
    for (int c = 0; c < 4; c++) lv[c] = m_level[c];
    chk("model_level", 32'(key_level), 32'(lv));
    chk("model_pulse", 32'(key_pulse), 32'(m_pulse));
    chk("model_any", 32'(any_pulse), 32'(|m_pulse));
    chk("model_idx", 32'(key_idx), 32'(m_idx));
    $display("cyc=%0d reset=%b key_n=%b level=%b pulse=%b any=%b idx=%0d",
             cyc, reset, key_n, key_level, key_pulse, any_pulse, key_idx);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    int ch, hold;
    bit exp_p;
    m_pulse = '0;
    m_idx   = '0;
    key_n   = 4'b1111;
    reset   = 1'b1;

    // Reset: 3 cycles, then 50 idle cycles with no level.
    steps(3);
    chk("rst_level", 32'(key_level), 32'h0);
    chk("rst_pulse", 32'(key_pulse), 32'h0);
    chk("rst_any", 32'(any_pulse), 32'h0);
    chk("rst_idx", 32'(key_idx), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_level", 32'(key_level), 32'h0);
    end

    // Clean press on key 2: strobe exactly 11 edges after the drive edge.
    key_n[2] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("clean_nopulse", 32'(key_pulse), 32'h0);
    end
    step();
    chk("clean_pulse", 32'(key_pulse), 32'h4);
    chk("clean_idx", 32'(key_idx), 32'h2);
    chk("clean_any", 32'(any_pulse), 32'h1);
    step();
    chk("clean_single", 32'(key_pulse), 32'h0);
    chk("clean_level", 32'(key_level), 32'h4);
    steps(7);
    key_n[2] = 1'b1;
    steps(10);
    chk("release_hold", 32'(key_level), 32'h4);
    step();
    chk("release_level", 32'(key_level), 32'h0);
    chk("release_nopulse", 32'(key_pulse), 32'h0);
    steps(5);

    // Bounce rejection on key 0.
    for (int i = 0; i < 40; i++) begin
      key_n[0] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      chk("bounce_pulse", 32'(key_pulse[0]), 32'h0);
      chk("bounce_level", 32'(key_level[0]), 32'h0);
    end
    key_n[0] = 1'b1;
    steps(15);

    // Simultaneous press on keys 1 and 3.
    key_n = 4'b0101;
    steps(10);
    step();
    chk("simul_pulse", 32'(key_pulse), 32'ha);
    chk("simul_idx", 32'(key_idx), 32'h1);
    chk("simul_any", 32'(any_pulse), 32'h1);
    key_n = 4'b1111;
    steps(20);

    // Reset pulsed during PRESS_CHK of key 0.
    key_n[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("midrst_pre", 32'(key_pulse), 32'h0);
    end
    reset = 1'b1;
    step();
    chk("midrst_rst_level", 32'(key_level), 32'h0);
    chk("midrst_rst_pulse", 32'(key_pulse), 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("midrst_wait", 32'(key_pulse), 32'h0);
    end
    step();
    chk("midrst_pulse", 32'(key_pulse), 32'h1);
    chk("midrst_idx", 32'(key_idx), 32'h0);
    key_n = 4'b1111;
    steps(20);

    // Long hold on key 3: press strobe, plus repeats when enabled.
    key_n[3] = 1'b0;
    for (int e = 1; e <= 75; e++) begin
      step();
      exp_p = (e == 11) || (AR && e >= 11 + RD && ((e - 11 - RD) % RP == 0) && e <= 61);
      chk("repeat_pulse", 32'(key_pulse[3]), 32'(exp_p));
      if (e == 60) key_n[3] = 1'b1;
    end
    steps(10);

    // Random activity with occasional resets.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      ch = $urandom_range(0, 3);
      key_n[ch] = ~key_n[ch];
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, 3);
        key_n[ch] = ~key_n[ch];
      end
      hold = $urandom_range(1, 20);
      steps(hold);
    end
    key_n = 4'b1111;
    steps(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input-conditioning stage directly upstream of the game top level.
- Takes the raw, asynchronous, active-low pushbuttons (`key[3:0]` on the board) and synchronises and debounces them.
- Produces clean level and single-cycle press strobes that feed the datapath's `key` input.
- Also provides an encoded "which key" index and an any-key strobe, used by the controller for user-entry capture.

Parameters:
- N_KEYS, 4, number of pushbutton channels.
- IDX_W, 2, width of `key_idx`; must satisfy 2^IDX_W >= N_KEYS.
- DEBOUNCE_CYCLES, 1000000, number of consecutive identical synchronised samples needed to accept a change (20 ms at 50 MHz).
- CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.
- REPEAT_DELAY, 25000000, cycles from an accepted press to the first auto-repeat strobe. Used only with the optional feature.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes. Used only with the optional feature.

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- key_n  in  N_KEYS  raw pushbuttons, asynchronous, active-low (0 = pressed).
- key_level  out  N_KEYS  debounced pressed state, 1 = pressed.
- key_pulse  out  N_KEYS  one-cycle strobe per accepted press (and per repeat, if enabled).
- any_pulse  out  1  OR of `key_pulse`.
- key_idx  out  IDX_W  index of the lowest-numbered channel with `key_pulse` high; holds its last value otherwise.

Behaviour:
- Clocking and reset: one clock domain (`clock_50`). Reset is synchronous and active-high and is sampled only on the rising edge of `clock_50`.
- Reset values:
  - `key_level` = 0, `key_pulse` = 0, `any_pulse` = 0, `key_idx` = 0.
  - Synchroniser flops = 1 (released).
  - All channel FSMs in RELEASED; all counters 0.
- Synchroniser: each channel passes through a 2-flop synchroniser on `key_n`. `p_sync` = inverted second-stage output (1 = pressed).
- Per-channel FSM (channels are fully independent). States: RELEASED, PRESS_CHK, PRESSED, REL_CHK.
  - RELEASED: `p_sync`=1 -> PRESS_CHK, counter=0. Otherwise stay.
  - PRESS_CHK: `p_sync`=0 -> RELEASED, counter=0 (bounce rejected). Else if counter==DEBOUNCE_CYCLES-1 -> PRESSED. Else counter+1.
  - PRESSED: `p_sync`=0 -> REL_CHK, counter=0. Otherwise stay.
  - REL_CHK: `p_sync`=1 -> PRESSED, counter=0. Else if counter==DEBOUNCE_CYCLES-1 -> RELEASED. Else counter+1.
- Outputs are registered:
  - `key_level[i]`=1 exactly while channel i is in PRESSED or REL_CHK.
  - `key_pulse[i]`=1 for exactly the one cycle in which `key_level[i]` first reads 1 (the PRESS_CHK->PRESSED transition).
  - No pulse is generated on release.
- Latency: raw input held low from clock edge t gives `key_level`/`key_pulse` rising at edge t+DEBOUNCE_CYCLES+3. Release latency is identical.
- Bounce shorter than DEBOUNCE_CYCLES consecutive samples produces no pulse and no change in `key_level`.
- Simultaneous presses:
  - Each channel pulses independently; several `key_pulse` bits may be high in the same cycle.
  - `any_pulse`=1 in that cycle.
  - `key_idx` = lowest set index, registered in the same cycle as the pulse.
- Reset mid-operation: all state returns to reset values on the next edge. A key held through reset is treated as a new press and pulses DEBOUNCE_CYCLES+3 cycles after reset deasserts.
- Counter must never wrap; it saturates at its compare value by construction.

Optional Feature:
- Macro: KEYCOND_AUTOREPEAT_EN.
- Defined:
  - Each channel in PRESSED (not REL_CHK) runs a repeat counter, cleared on entry to PRESSED.
  - The first extra `key_pulse` occurs REPEAT_DELAY cycles after the press pulse; further pulses follow every REPEAT_PERIOD cycles while the channel stays PRESSED.
  - Entering REL_CHK clears the repeat counter. A return REL_CHK->PRESSED restarts it from REPEAT_DELAY and generates no pulse.
  - `any_pulse` and `key_idx` follow repeat pulses.
- Undefined: no repeat logic is synthesised; exactly one pulse per accepted press.

Test Plan (bench uses DEBOUNCE_CYCLES=8, CNT_W=4, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Reset checks:
  - Reset asserted 3 cycles with `key_n`=4'b1111 -> all outputs 0.
  - `key_level` stays 0 for 50 cycles after release of reset.
- Clean press: `key_n[2]` driven 0 at edge t and held -> `key_pulse`=4'b0100 for one cycle at edge t+11, `key_idx`=2, `any_pulse`=1. `key_level[2]` stays 1 until release plus 11 cycles.
- Bounce rejection: `key_n[0]` toggled 0/1 every 3 cycles for 40 cycles, then held 1 -> no `key_pulse`, `key_level[0]` stays 0.
- Simultaneous press: `key_n[1]` and `key_n[3]` driven 0 on the same edge -> `key_pulse`=4'b1010 in one cycle, `key_idx`=1.
- Reset mid-press: `key_n[0]` held 0, reset pulsed 1 cycle at t+6 (during PRESS_CHK) -> no pulse before reset; single pulse at 11 cycles after reset deasserts.
- With KEYCOND_AUTOREPEAT_EN: `key_n[3]` held 0 for 60 cycles -> pulses at press edge p, p+20, p+25, p+30, ..., stopping at release. Without the macro, only the pulse at p.
